derm_input_pingpong_buffer: RTL and testbench
=============================================

// Module: derm_input_pingpong_buffer
// PURPOSE
//  Next-generation de-rate-matching input buffer for NUM_USERS user lanes.
//  Ping-pong, double-banked storage: the write side fills one bank while the
//  de-rate-matching core randomly reads the other. Adds a valid/ready write
//  handshake, auto-incrementing write address, per-bank length capture, bank
//  ownership FSM and a zero-mask on out-of-range reads. Placed between the
//  LLR demapper output and the de-rate-matching core.
// PARAMETERS
//  DATA_W     48  LLR word width per user lane
//  ADDR_W     11  address width within one bank; DEPTH = 2**ADDR_W words
//  NUM_USERS  16  user lanes; one DualPort_SRAM (DATA_W x 2*DEPTH) per lane
// PORTS
//  i_core_clk       in   1                 core clock
//  i_rx_rstn        in   1                 async active-low reset
//  i_rx_fsm_rstn    in   1                 sync active-low soft clear
//  i_wr_valid       in   1                 write beat valid
//  o_wr_ready       out  1                 write bank free to accept beats
//  i_wr_last        in   1                 final beat of block (qualified by valid)
//  i_wr_user_en     in   NUM_USERS         per-lane write enable for this beat
//  i_wr_data        in   NUM_USERS*DATA_W  lane k at [k*DATA_W +: DATA_W]
//  o_wr_autocommit  out  1                 sticky: a bank was committed at DEPTH without last
//  o_rd_avail       out  1                 a full bank is owned by the read side
//  o_rd_len         out  ADDR_W+1          beat count of the readable bank (1..DEPTH)
//  i_rd_req         in   1                 read request
//  i_rd_addr        in   ADDR_W            read address within readable bank
//  o_rd_valid       out  1                 o_rd_data valid
//  o_rd_data        out  NUM_USERS*DATA_W  read data, lane k at [k*DATA_W +: DATA_W]
//  i_rd_release     in   1                 reader finished; return bank to writer
// BEHAVIOUR
//  Reset (i_rx_rstn=0, async) or soft clear (i_rx_fsm_rstn=0 at clock edge):
//   wr_bank=0, rd_bank=0, full[1:0]=0, wr_addr=0, len regs=0; o_wr_ready=1,
//   o_rd_avail=0, o_rd_len=0, o_rd_valid=0, o_rd_data=0, o_wr_autocommit=0.
//   SRAM contents are not cleared. A partly written block is discarded.
//  Bank FSM (per bank): FREE -> (commit) FULL -> (release) FREE.
//   Writer owns bank wr_bank while FREE; reader owns rd_bank while FULL.
//  Write: beat accepted = i_wr_valid & o_wr_ready; o_wr_ready = ~full[wr_bank].
//   Accepted beat writes lanes with i_wr_user_en[k]=1 at SRAM address
//   {wr_bank, wr_addr}. Lanes with en=0 keep stale data. wr_addr increments
//   on every accepted beat, whatever the enables are.
//   Commit on accepted beat with i_wr_last=1 OR wr_addr==DEPTH-1:
//   len[wr_bank]<=wr_addr+1, full[wr_bank]<=1, wr_bank toggles, wr_addr<=0.
//   A commit at DEPTH-1 with i_wr_last=0 sets o_wr_autocommit; it clears
//   only on reset or soft clear. Beats offered with o_wr_ready=0 are not
//   written; the source holds them.
//  Read: o_rd_avail = full[rd_bank]; o_rd_len = len[rd_bank] (0 when not avail).
//   i_rd_req with o_rd_avail=1 reads {rd_bank, i_rd_addr}. Latency 1 cycle:
//   o_rd_valid=1 and o_rd_data are valid on the next cycle. If
//   i_rd_addr >= o_rd_len, o_rd_valid=1 and o_rd_data=0. i_rd_req with
//   o_rd_avail=0 is ignored (o_rd_valid=0 next cycle). o_rd_data holds its
//   value when o_rd_valid=0. Back-to-back requests give one word per cycle.
//  Release: i_rd_release with o_rd_avail=1 clears full[rd_bank] and toggles
//   rd_bank. It is ignored when avail=0. A read issued in the release cycle
//   completes on the old bank.
//  Simultaneous: commit and release in the same cycle act on different banks
//   and both take effect. If both banks were full, the released bank is FREE
//   and o_wr_ready=1 on the next cycle. Reads and writes always target
//   different banks, so there is no read/write address collision.
// TESTING
//  T1 reset: hold i_rx_rstn=0 mid-block -> all outputs at reset values;
//     the next block lands in bank 0 at addr 0.
//  T2 basic: 5 beats, all lanes en, last on beat 5 -> o_rd_avail=1, o_rd_len=5;
//     read addr 0..4 returns the written data 1 cycle after each request.
//  T3 ping-pong: write block A (3 beats) then block B (7 beats) without
//     release -> B accepted, then o_wr_ready=0. Release A -> o_rd_len=7 and
//     o_wr_ready=1 next cycle.
//  T4 autocommit: DEPTH beats with no last -> commit, o_rd_len=DEPTH,
//     o_wr_autocommit=1; beat DEPTH+1 goes to bank 1 at addr 0.
//  T5 masking/enables: lane 3 en=0 on all beats -> lane 3 reads stale data
//     while other lanes read correctly; read addr=o_rd_len -> o_rd_valid=1,
//     data=0.
//  T6 collisions: commit and release in the same cycle; i_rd_req/i_rd_release
//     while avail=0 -> ignored; i_rx_fsm_rstn=0 pulse mid-block -> state
//     cleared, o_rd_avail=0.

Source files
------------

// File: rtl/derm_input_pingpong_buffer_if.sv
// Write/read handshake bundle for the de-rate-matching ping-pong input buffer.
// The master side is the LLR source plus the de-rate-matching reader; the slave side is the buffer.
interface derm_input_pingpong_buffer_if #(
  parameter int DATA_W    = 48,
  parameter int ADDR_W    = 11,
  parameter int NUM_USERS = 16
);
  logic                        wr_valid;
  logic                        wr_ready;
  logic                        wr_last;
  logic [NUM_USERS-1:0]        wr_user_en;
  logic [NUM_USERS*DATA_W-1:0] wr_data;
  logic                        wr_autocommit;
  logic                        rd_avail;
  logic [ADDR_W:0]             rd_len;
  logic                        rd_req;
  logic [ADDR_W-1:0]           rd_addr;
  logic                        rd_valid;
  logic [NUM_USERS*DATA_W-1:0] rd_data;
  logic                        rd_release;

  modport master (
    output wr_valid, wr_last, wr_user_en, wr_data, rd_req, rd_addr, rd_release,
    input  wr_ready, wr_autocommit, rd_avail, rd_len, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_last, wr_user_en, wr_data, rd_req, rd_addr, rd_release,
    output wr_ready, wr_autocommit, rd_avail, rd_len, rd_valid, rd_data
  );
endinterface

// File: rtl/derm_input_pingpong_buffer.sv
// Double-banked LLR input buffer: the writer fills one bank while the de-rate-matching
// core randomly reads the other; one two-bank memory per user lane.
module derm_input_pingpong_buffer #(
  parameter int DATA_W    = 48,
  parameter int ADDR_W    = 11,
  parameter int NUM_USERS = 16
) (
  input logic                         i_core_clk,
  input logic                         i_rx_rstn,
  input logic                         i_rx_fsm_rstn,
  derm_input_pingpong_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic {BANK_FREE = 1'b0, BANK_FULL = 1'b1} bank_state_e;

  bank_state_e       bank_st_r [2];
  bank_state_e       bank_st_nxt_s [2];
  logic [ADDR_W:0]   len_r [2];
  logic [ADDR_W:0]   len_nxt_s [2];
  logic              wr_bank_r, rd_bank_r;
  logic              wr_bank_nxt_s, rd_bank_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r;
  logic              wr_ready_r, rd_avail_r, rd_valid_r, autocommit_r;
  logic [ADDR_W:0]   rd_len_r;
  logic              wr_accept_s, commit_s, release_s, rd_fire_s, rd_in_range_s;
  logic              wr_ready_nxt_s, rd_avail_nxt_s;
  logic [ADDR_W:0]   rd_len_nxt_s;
  logic [ADDR_W:0]   wr_ptr_s, rd_ptr_s;

  // Handshake decode and next-state of bank ownership, so status outputs can be registered.
  always_comb begin
    wr_accept_s   = bus.wr_valid & wr_ready_r;
    commit_s      = wr_accept_s & (bus.wr_last | (wr_addr_r == ADDR_LAST));
    release_s     = bus.rd_release & rd_avail_r;
    rd_fire_s     = bus.rd_req & rd_avail_r;
    rd_in_range_s = ({1'b0, bus.rd_addr} < rd_len_r);
    wr_ptr_s      = {wr_bank_r, wr_addr_r};
    rd_ptr_s      = {rd_bank_r, bus.rd_addr};
    wr_bank_nxt_s = commit_s ? ~wr_bank_r : wr_bank_r;
    rd_bank_nxt_s = release_s ? ~rd_bank_r : rd_bank_r;
    for (int b = 0; b < 2; b++) begin
      bank_st_nxt_s[b] = (commit_s && (wr_bank_r == b[0])) ? BANK_FULL :
                         (release_s && (rd_bank_r == b[0])) ? BANK_FREE : bank_st_r[b];
      len_nxt_s[b]     = (commit_s && (wr_bank_r == b[0])) ?
                         ({1'b0, wr_addr_r} + {{ADDR_W{1'b0}}, 1'b1}) : len_r[b];
    end
    wr_ready_nxt_s = (bank_st_nxt_s[wr_bank_nxt_s] == BANK_FREE);
    rd_avail_nxt_s = (bank_st_nxt_s[rd_bank_nxt_s] == BANK_FULL);
    rd_len_nxt_s   = rd_avail_nxt_s ? len_nxt_s[rd_bank_nxt_s] : {(ADDR_W+1){1'b0}};
  end

  // Bank ownership, write pointer and registered status outputs.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      bank_st_r[0] <= BANK_FREE;
      bank_st_r[1] <= BANK_FREE;
      len_r[0]     <= {(ADDR_W+1){1'b0}};
      len_r[1]     <= {(ADDR_W+1){1'b0}};
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b0;
      wr_addr_r    <= {ADDR_W{1'b0}};
      wr_ready_r   <= 1'b1;
      rd_avail_r   <= 1'b0;
      rd_len_r     <= {(ADDR_W+1){1'b0}};
      rd_valid_r   <= 1'b0;
      autocommit_r <= 1'b0;
    end else if (!i_rx_fsm_rstn) begin
      bank_st_r[0] <= BANK_FREE;
      bank_st_r[1] <= BANK_FREE;
      len_r[0]     <= {(ADDR_W+1){1'b0}};
      len_r[1]     <= {(ADDR_W+1){1'b0}};
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b0;
      wr_addr_r    <= {ADDR_W{1'b0}};
      wr_ready_r   <= 1'b1;
      rd_avail_r   <= 1'b0;
      rd_len_r     <= {(ADDR_W+1){1'b0}};
      rd_valid_r   <= 1'b0;
      autocommit_r <= 1'b0;
    end else begin
      bank_st_r[0] <= bank_st_nxt_s[0];
      bank_st_r[1] <= bank_st_nxt_s[1];
      len_r[0]     <= len_nxt_s[0];
      len_r[1]     <= len_nxt_s[1];
      wr_bank_r    <= wr_bank_nxt_s;
      rd_bank_r    <= rd_bank_nxt_s;
      wr_addr_r    <= commit_s ? {ADDR_W{1'b0}} :
                      wr_accept_s ? (wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1}) : wr_addr_r;
      wr_ready_r   <= wr_ready_nxt_s;
      rd_avail_r   <= rd_avail_nxt_s;
      rd_len_r     <= rd_len_nxt_s;
      rd_valid_r   <= rd_fire_s;
      autocommit_r <= autocommit_r | (commit_s & ~bus.wr_last);
    end
  end

  for (genvar k = 0; k < NUM_USERS; k++) begin : g_lane
    logic [DATA_W-1:0] mem [2*DEPTH];
    logic [DATA_W-1:0] rd_word_r;

    // Lane memory: not cleared by reset; lanes with enable low keep stale contents.
    always_ff @(posedge i_core_clk) begin
      if (wr_accept_s && bus.wr_user_en[k] && i_rx_fsm_rstn) begin
        mem[wr_ptr_s] <= bus.wr_data[k*DATA_W +: DATA_W];
      end else begin
        mem[wr_ptr_s] <= mem[wr_ptr_s];
      end
    end

    // Read word register; beyond the captured block length the word is forced to zero.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
      if (!i_rx_rstn) begin
        rd_word_r <= {DATA_W{1'b0}};
      end else if (!i_rx_fsm_rstn) begin
        rd_word_r <= {DATA_W{1'b0}};
      end else if (rd_fire_s) begin
        rd_word_r <= rd_in_range_s ? mem[rd_ptr_s] : {DATA_W{1'b0}};
      end else begin
        rd_word_r <= rd_word_r;
      end
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = rd_word_r;
  end

  assign bus.wr_ready      = wr_ready_r;
  assign bus.rd_avail      = rd_avail_r;
  assign bus.rd_len        = rd_len_r;
  assign bus.rd_valid      = rd_valid_r;
  assign bus.wr_autocommit = autocommit_r;
endmodule

// File: tb/tb_derm_input_pingpong_buffer.sv
// Directed bench for the ping-pong input buffer: reset, ping-pong ownership, autocommit,
// lane enables, out-of-range masking, simultaneous commit/release and soft clear.
module tb_derm_input_pingpong_buffer;
  localparam int DATA_W    = 48;
  localparam int ADDR_W    = 11;
  localparam int NUM_USERS = 16;
  localparam int DEPTH     = 2048;
  localparam int BW        = NUM_USERS * DATA_W;
  localparam logic [15:0] ALL_EN = 16'hFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fsm_rstn = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  derm_input_pingpong_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_USERS(NUM_USERS)) bus ();

  derm_input_pingpong_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_USERS(NUM_USERS)) dut (
    .i_core_clk    (clk),
    .i_rx_rstn     (rst_n),
    .i_rx_fsm_rstn (fsm_rstn),
    .bus           (bus)
  );

  function automatic logic [DATA_W-1:0] pat(int tag, int beat, int lane);
    return {16'(tag), 16'(beat), 16'(lane)};
  endfunction

  // Expected word: enabled lanes carry this block, disabled lanes the stale block.
  function automatic logic [BW-1:0] row(int tag, int beat, logic [15:0] en, int stale);
    logic [BW-1:0] r;
    for (int k = 0; k < NUM_USERS; k++)
      r[k*DATA_W +: DATA_W] = en[k] ? pat(tag, beat, k) : pat(stale, beat, k);
    return r;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wblock(int tag, int n, logic last_at_end, logic [15:0] en);
    for (int b = 0; b < n; b++) begin
      bus.wr_valid   = 1'b1;
      bus.wr_user_en = en;
      bus.wr_data    = row(tag, b, ALL_EN, 0);
      bus.wr_last    = last_at_end && (b == n - 1);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic rd(int addr, logic [BW-1:0] exp, string tag);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 11'(addr);
    tick();
    bus.rd_req  = 1'b0;
    check({tag, "_valid"}, BW'(bus.rd_valid), BW'(1'b1));
    check(tag, bus.rd_data, exp);
  endtask

  task automatic rel();
    bus.rd_release = 1'b1;
    tick();
    bus.rd_release = 1'b0;
  endtask

  task automatic check_idle(string tag);
    check({tag, "_ready"}, BW'(bus.wr_ready), BW'(1'b1));
    check({tag, "_avail"}, BW'(bus.rd_avail), BW'(1'b0));
    check({tag, "_len"}, BW'(bus.rd_len), BW'(0));
    check({tag, "_valid"}, BW'(bus.rd_valid), BW'(1'b0));
    check({tag, "_data"}, bus.rd_data, BW'(0));
    check({tag, "_autoc"}, BW'(bus.wr_autocommit), BW'(1'b0));
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.wr_user_en = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_release = 1'b0;

    // T1: reset values, then an async reset in the middle of a block
    #12;
    check_idle("t1_por");
    rst_n = 1'b1;
    tick();
    wblock(9, 2, 1'b0, ALL_EN);
    rst_n = 1'b0;
    #2;
    check_idle("t1_mid");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T2: basic 5-beat block into bank 0 address 0
    wblock(1, 5, 1'b1, ALL_EN);
    check("t2_avail", BW'(bus.rd_avail), BW'(1'b1));
    check("t2_len", BW'(bus.rd_len), BW'(5));
    check("t2_ready", BW'(bus.wr_ready), BW'(1'b1));
    for (int a = 0; a < 5; a++) rd(a, row(1, a, ALL_EN, 0), $sformatf("t2_rd%0d", a));
    bus.rd_req = 1'b1; bus.rd_addr = 11'd1;
    tick();
    check("t2_b2b1", bus.rd_data, row(1, 1, ALL_EN, 0));
    bus.rd_addr = 11'd2;
    tick();
    check("t2_b2b2", bus.rd_data, row(1, 2, ALL_EN, 0));
    check("t2_b2b2_valid", BW'(bus.rd_valid), BW'(1'b1));
    bus.rd_req = 1'b0;
    tick();
    check("t2_novalid", BW'(bus.rd_valid), BW'(1'b0));
    check("t2_hold", bus.rd_data, row(1, 2, ALL_EN, 0));
    rel();
    check("t2_rel_avail", BW'(bus.rd_avail), BW'(1'b0));
    check("t2_rel_len", BW'(bus.rd_len), BW'(0));

    // T3: two blocks without release, back-pressure, release reopens the writer
    wblock(2, 3, 1'b1, ALL_EN);
    check("t3_lenA", BW'(bus.rd_len), BW'(3));
    wblock(3, 7, 1'b1, ALL_EN);
    check("t3_full_ready", BW'(bus.wr_ready), BW'(1'b0));
    check("t3_lenA2", BW'(bus.rd_len), BW'(3));
    wblock(4, 1, 1'b1, ALL_EN);
    check("t3_still_full", BW'(bus.wr_ready), BW'(1'b0));
    rel();
    check("t3_lenB", BW'(bus.rd_len), BW'(7));
    check("t3_ready", BW'(bus.wr_ready), BW'(1'b1));
    check("t3_avail", BW'(bus.rd_avail), BW'(1'b1));
    rd(6, row(3, 6, ALL_EN, 0), "t3_rdB6");
    rel();

    // T4: DEPTH beats without last commit automatically
    wblock(5, DEPTH - 1, 1'b0, ALL_EN);
    check("t4_pre_autoc", BW'(bus.wr_autocommit), BW'(1'b0));
    check("t4_pre_avail", BW'(bus.rd_avail), BW'(1'b0));
    bus.wr_valid = 1'b1; bus.wr_data = row(5, DEPTH - 1, ALL_EN, 0);
    tick();
    bus.wr_valid = 1'b0;
    check("t4_autoc", BW'(bus.wr_autocommit), BW'(1'b1));
    check("t4_len", BW'(bus.rd_len), BW'(DEPTH));
    check("t4_ready", BW'(bus.wr_ready), BW'(1'b1));
    wblock(6, 1, 1'b1, ALL_EN);
    check("t4_both_full", BW'(bus.wr_ready), BW'(1'b0));
    rd(DEPTH - 1, row(5, DEPTH - 1, ALL_EN, 0), "t4_rd_top");
    rd(0, row(5, 0, ALL_EN, 0), "t4_rd0");
    rel();
    check("t4_next_len", BW'(bus.rd_len), BW'(1));
    rd(0, row(6, 0, ALL_EN, 0), "t4_next_rd0");
    rel();

    // T5: lane 3 disabled keeps stale data; reads at or beyond length return zero
    wblock(7, 4, 1'b1, 16'hFFF7);
    check("t5_len", BW'(bus.rd_len), BW'(4));
    rd(1, row(7, 1, 16'hFFF7, 5), "t5_rd1");
    rd(3, row(7, 3, 16'hFFF7, 5), "t5_rd3");
    rd(4, BW'(0), "t5_rd_len");
    rd(DEPTH - 1, BW'(0), "t5_rd_top");
    rel();

    // T6: ignored read/release, simultaneous commit+release, soft clear
    bus.rd_req = 1'b1; bus.rd_addr = 11'd0;
    tick();
    bus.rd_req = 1'b0;
    check("t6_ign_valid", BW'(bus.rd_valid), BW'(1'b0));
    rel();
    check("t6_ign_rel", BW'(bus.rd_avail), BW'(1'b0));
    wblock(8, 2, 1'b1, ALL_EN);
    check("t6_avail", BW'(bus.rd_avail), BW'(1'b1));
    check("t6_len", BW'(bus.rd_len), BW'(2));
    wblock(10, 2, 1'b0, ALL_EN);
    bus.wr_valid = 1'b1; bus.wr_last = 1'b1; bus.wr_data = row(10, 2, ALL_EN, 0);
    bus.rd_release = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.rd_release = 1'b0;
    check("t6_sim_avail", BW'(bus.rd_avail), BW'(1'b1));
    check("t6_sim_len", BW'(bus.rd_len), BW'(3));
    check("t6_sim_ready", BW'(bus.wr_ready), BW'(1'b1));
    rd(2, row(10, 2, ALL_EN, 0), "t6_sim_rd2");
    check("t6_autoc_sticky", BW'(bus.wr_autocommit), BW'(1'b1));
    wblock(11, 1, 1'b0, ALL_EN);
    fsm_rstn = 1'b0;
    tick();
    fsm_rstn = 1'b1;
    check_idle("t6_srst");
    wblock(12, 1, 1'b1, ALL_EN);
    check("t6_post_len", BW'(bus.rd_len), BW'(1));
    rd(0, row(12, 0, ALL_EN, 0), "t6_post_rd0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
